// File: rtl/fetch_predict.sv
// Single-issue fetch stage with a direct-mapped BTB and 2-bit counters.
// Decode resolves the held instruction; mispredicts redirect the PC with one bubble.
module fetch_predict #(
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IM_Addr,
  output logic        IM_Req,
  input  logic        IM_Ready,
  input  logic [31:0] IM_Instr,
  input  logic        WANT_FREEZE,
  input  logic        is_branch,
  input  logic        is_taken,
  input  logic [31:0] alt_address,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] Instr1_PC_Plus4_OUT,
  output logic        Instr1_Valid_OUT,
  output logic        Pred_Taken_OUT,
  output logic [31:0] Branch_Count,
  output logic [31:0] Mispredict_Count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [31:0] pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pred_target;
  logic        out_valid;
  logic        out_pred;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit;
  logic             lk_taken;
  logic [31:0]      pred_next;
  logic [IDX_W-1:0] up_idx;
  logic             up_hit;
  logic             consume;
  logic             resolve;
  logic             actual_taken;
  logic             mispredict;
  logic [31:0]      corrected_pc;
  logic [31:0]      out_pc_plus4;

  // Prediction for the PC being fetched, read from the pre-update BTB contents.
  always_comb begin
    lk_idx    = pc[IDX_W+1:2];
    lk_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc[31:IDX_W+2]);
    lk_taken  = lk_hit && btb_ctr[lk_idx][1];
    pred_next = lk_taken ? btb_target[lk_idx] : pc + 32'd4;
  end

  always_comb begin
    out_pc_plus4 = out_pc + 32'd4;
    up_idx       = out_pc[IDX_W+1:2];
    up_hit       = btb_valid[up_idx] && (btb_tag[up_idx] == out_pc[31:IDX_W+2]);
    consume      = !WANT_FREEZE;
    resolve      = consume && out_valid;
    actual_taken = is_branch && is_taken;
    mispredict   = resolve &&
                   ((actual_taken && (!out_pred || (out_pred_target != alt_address))) ||
                    (!actual_taken && out_pred));
    corrected_pc = actual_taken ? alt_address : out_pc_plus4;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc               <= RESET_PC;
      out_instr        <= '0;
      out_pc           <= '0;
      out_pred_target  <= '0;
      out_valid        <= 1'b0;
      out_pred         <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (consume) begin
      if (resolve && is_branch) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict) begin
        pc               <= corrected_pc;
        out_instr        <= '0;
        out_valid        <= 1'b0;
        out_pred         <= 1'b0;
        mispredict_count <= mispredict_count + 32'd1;
      end else if (IM_Ready) begin
        pc              <= pred_next;
        out_instr       <= IM_Instr;
        out_pc          <= pc;
        out_valid       <= 1'b1;
        out_pred        <= lk_taken;
        out_pred_target <= pred_next;
      end else begin
        out_instr <= '0;
        out_valid <= 1'b0;
        out_pred  <= 1'b0;
      end
    end
  end

  // Training happens at the index of the instruction being resolved, not the one being fetched.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'd0;
      end
    end else if (resolve) begin
      if (is_branch) begin
        if (up_hit) begin
          if (is_taken) begin
            btb_target[up_idx] <= alt_address;
            if (btb_ctr[up_idx] != 2'd3) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
          end else if (btb_ctr[up_idx] != 2'd0) begin
            btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
          end
        end else if (is_taken) begin
          btb_valid[up_idx]  <= 1'b1;
          btb_tag[up_idx]    <= out_pc[31:IDX_W+2];
          btb_target[up_idx] <= alt_address;
          btb_ctr[up_idx]    <= 2'd2;
        end
      end else if (out_pred) begin
        btb_valid[up_idx] <= 1'b0;
      end
    end
  end

  assign IM_Addr             = pc;
  assign IM_Req              = !WANT_FREEZE;
  assign Instr1_OUT          = out_instr;
  assign Instr1_PC_OUT       = out_pc;
  assign Instr1_PC_Plus4_OUT = out_pc_plus4;
  assign Instr1_Valid_OUT    = out_valid;
  assign Pred_Taken_OUT      = out_pred;
  assign Branch_Count        = branch_count;
  assign Mispredict_Count    = mispredict_count;

endmodule
